// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: shared constants and lookup functions for the PS/2 keyboard display.
package ps2_kbd_pkg;
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] s);
    case (s)
      8'h1C: return 8'h61; 8'h32: return 8'h62; 8'h21: return 8'h63; 8'h23: return 8'h64;
      8'h24: return 8'h65; 8'h2B: return 8'h66; 8'h34: return 8'h67; 8'h33: return 8'h68;
      8'h43: return 8'h69; 8'h3B: return 8'h6A; 8'h42: return 8'h6B; 8'h4B: return 8'h6C;
      8'h3A: return 8'h6D; 8'h31: return 8'h6E; 8'h44: return 8'h6F; 8'h4D: return 8'h70;
      8'h15: return 8'h71; 8'h2D: return 8'h72; 8'h1B: return 8'h73; 8'h2C: return 8'h74;
      8'h3C: return 8'h75; 8'h2A: return 8'h76; 8'h1D: return 8'h77; 8'h22: return 8'h78;
      8'h35: return 8'h79; 8'h1A: return 8'h7A;
      8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32; 8'h26: return 8'h33;
      8'h25: return 8'h34; 8'h2E: return 8'h35; 8'h36: return 8'h36; 8'h3D: return 8'h37;
      8'h3E: return 8'h38; 8'h46: return 8'h39;
      8'h29: return 8'h20; 8'h5A: return 8'h0D; 8'h66: return 8'h08;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/ps2_kbd_display_if.sv
// ps2_kbd_display_if: PS/2 pins in, decoded key state and segment digits out.
interface ps2_kbd_display_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic [7:0] ascii;
  logic [6:0] key_count;
  logic       frame_err;
  logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5;
  modport master (output ps2_clk, ps2_data,
                  input scan_code, ascii, key_count, frame_err, seg0, seg1, seg2, seg3, seg4, seg5);
  modport slave  (input ps2_clk, ps2_data,
                  output scan_code, ascii, key_count, frame_err, seg0, seg1, seg2, seg3, seg4, seg5);
endinterface

// File: rtl/ps2_kbd_display_ps2_rx.sv
// ps2_rx: synchronises the PS/2 pins and assembles/validates 11-bit frames.
module ps2_rx #(
  parameter int SYNC_STAGES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);
  logic [SYNC_STAGES:0]   ck_q;
  logic [SYNC_STAGES-1:0] dt_q;
  logic [10:0] sr_q, frame_d;
  logic [3:0]  cnt_q;
  logic [7:0]  byte_q;
  logic        valid_q, err_q, fall, last, ok;
  // ck_q carries one extra stage past the synchroniser so the edge compares settled values
  assign fall = ck_q[SYNC_STAGES] && !ck_q[SYNC_STAGES-1];
  always_comb begin
    frame_d = {dt_q[SYNC_STAGES-1], sr_q[10:1]};
    last    = fall && cnt_q == 4'd10;
    ok      = !frame_d[0] && frame_d[10] && ^frame_d[9:1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_q    <= '1;
      dt_q    <= '1;
      sr_q    <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ck_q    <= {ck_q[SYNC_STAGES-1:0], ps2_clk_i};
      dt_q    <= {dt_q[SYNC_STAGES-2:0], ps2_data_i};
      sr_q    <= fall ? frame_d : sr_q;
      cnt_q   <= last ? 4'd0 : fall ? cnt_q + 4'd1 : cnt_q;
      byte_q  <= last ? frame_d[8:1] : byte_q;
      valid_q <= last && ok;
      err_q   <= last && !ok;
    end
  end
  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = err_q;
endmodule

// File: rtl/ps2_kbd_display.sv
// ps2_kbd_display: PS/2 keyboard decoder with scancode/ASCII/release-count readout
// on six active-low seven-segment digits.
module ps2_kbd_display
  import ps2_kbd_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int COUNT_MOD   = 100
) (
  input  logic clk,
  input  logic rst,
  ps2_kbd_display_if.slave kbd_io
);
  logic [7:0] rx_byte, scan_q, scan_d, ascii_q, ascii_d;
  logic [6:0] cnt_q, cnt_d;
  logic [3:0] units, tens;
  logic       rx_valid, rx_err, brk_q, brk_d, take;
  ps2_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk_i    (kbd_io.ps2_clk),
    .ps2_data_i   (kbd_io.ps2_data),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_err)
  );
  // E0 prefixes are dropped entirely so extended keys count like their base key
  always_comb begin
    take    = rx_valid && rx_byte != BREAK_CODE && rx_byte != EXT_CODE;
    brk_d   = (rx_valid && rx_byte == BREAK_CODE) ? 1'b1 : take ? 1'b0 : brk_q;
    scan_d  = take ? rx_byte : scan_q;
    ascii_d = take ? scan_to_ascii(rx_byte) : ascii_q;
    cnt_d   = !(take && brk_q) ? cnt_q : cnt_q == 7'(COUNT_MOD - 1) ? 7'd0 : cnt_q + 7'd1;
    units   = 4'(cnt_q % 7'd10);
    tens    = 4'(cnt_q / 7'd10);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk_q   <= 1'b0;
      scan_q  <= '0;
      ascii_q <= '0;
      cnt_q   <= '0;
    end else begin
      brk_q   <= brk_d;
      scan_q  <= scan_d;
      ascii_q <= ascii_d;
      cnt_q   <= cnt_d;
    end
  end
  assign kbd_io.scan_code = scan_q;
  assign kbd_io.ascii     = ascii_q;
  assign kbd_io.key_count = cnt_q;
  assign kbd_io.frame_err = rx_err;
  assign kbd_io.seg0      = hex_to_seg(scan_q[3:0]);
  assign kbd_io.seg1      = hex_to_seg(scan_q[7:4]);
  assign kbd_io.seg2      = hex_to_seg(ascii_q[3:0]);
  assign kbd_io.seg3      = hex_to_seg(ascii_q[7:4]);
  assign kbd_io.seg4      = hex_to_seg(units);
  assign kbd_io.seg5      = hex_to_seg(tens);
endmodule

// File: tb/tb_ps2_kbd_display.sv
// tb_ps2_kbd_display: directed and randomized PS/2 frames checked against a key-level model.
module tb_ps2_kbd_display;
  logic clk = 1'b0, rst = 1'b1;
  int   n_assert = 0, n_fail = 0, err_seen = 0;
  ps2_kbd_display_if kbd ();
  ps2_kbd_display dut (.clk(clk), .rst(rst), .kbd_io(kbd));
  always #5 clk = ~clk;
  always @(negedge clk) if (kbd.frame_err === 1'b1) err_seen++;
  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] segs [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] m_scan = 0, m_ascii = 0;
  int m_cnt = 0, m_err = 0;
  bit m_brk = 0;
  function automatic logic [7:0] ascii_ref(input logic [7:0] b);
    for (int i = 0; i < 26; i++) if (letters[i] == b) return 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++) if (digits[i] == b) return 8'h30 + 8'(i);
    if (b == 8'h29) return 8'h20;
    if (b == 8'h5A) return 8'h0D;
    if (b == 8'h66) return 8'h08;
    return 8'h00;
  endfunction
  task automatic model(input logic [7:0] b, input bit bad);
    if (bad) m_err++;
    else if (b == 8'hF0) m_brk = 1;
    else if (b != 8'hE0) begin
      m_scan  = b;
      m_ascii = ascii_ref(b);
      if (m_brk) m_cnt = (m_cnt + 1) % 100;
      m_brk = 0;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    @(negedge clk);
    chk({tag, ".scan"}, 32'(kbd.scan_code), 32'(m_scan));
    chk({tag, ".ascii"}, 32'(kbd.ascii), 32'(m_ascii));
    chk({tag, ".count"}, 32'(kbd.key_count), 32'(m_cnt));
    chk({tag, ".err"}, 32'(err_seen), 32'(m_err));
    chk({tag, ".seg0"}, 32'(kbd.seg0), 32'(segs[m_scan % 16]));
    chk({tag, ".seg1"}, 32'(kbd.seg1), 32'(segs[m_scan / 16]));
    chk({tag, ".seg2"}, 32'(kbd.seg2), 32'(segs[m_ascii % 16]));
    chk({tag, ".seg3"}, 32'(kbd.seg3), 32'(segs[m_ascii / 16]));
    chk({tag, ".seg4"}, 32'(kbd.seg4), 32'(segs[m_cnt % 10]));
    chk({tag, ".seg5"}, 32'(kbd.seg5), 32'(segs[m_cnt / 10]));
  endtask
  task automatic send(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0,
                      input int nbits = 11);
    logic [10:0] f;
    f = {~bad_stop, ~^b ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kbd.ps2_data = f[i];
      repeat (5) @(posedge clk);
      kbd.ps2_clk = 1'b0;
      repeat (5) @(posedge clk);
      kbd.ps2_clk = 1'b1;
    end
    repeat (10) @(posedge clk);
    if (nbits == 11) model(b, bad_par || bad_stop);
  endtask
  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_scan = 0; m_ascii = 0; m_cnt = 0; m_brk = 0;
    repeat (2) @(posedge clk);
  endtask
  initial begin
    logic [7:0] b;
    int r;
    kbd.ps2_clk = 1'b1;
    kbd.ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(posedge clk);
    check_all("reset");
    chk("reset.frame_err", 32'(kbd.frame_err), 32'd0);
    send(8'h1C);
    check_all("make_1c");
    chk("make_1c.seg0_lit", 32'(kbd.seg0), 32'hC6);
    chk("make_1c.seg3_lit", 32'(kbd.seg3), 32'h82);
    send(8'hF0); send(8'h1C);
    check_all("release_1c");
    chk("release_1c.count_lit", 32'(kbd.key_count), 32'd1);
    send(8'hF0);
    check_all("break_only");
    send(8'hF0); send(8'hE0);
    check_all("ext_ignored");
    send(8'h45);
    check_all("double_break");
    chk("double_break.count_lit", 32'(kbd.key_count), 32'd2);
    chk("double_break.ascii_lit", 32'(kbd.ascii), 32'h30);
    send(8'h1C, 1, 0);
    check_all("bad_parity");
    send(8'h1C, 0, 1);
    check_all("bad_stop");
    chk("bad_frames.err_lit", 32'(err_seen), 32'd2);
    do_reset();
    check_all("reset2");
    for (int i = 0; i < 100; i++) begin
      send(8'h16); send(8'hF0); send(8'h16);
      if (i == 98) check_all("wrap_99");
    end
    check_all("wrap_0");
    chk("wrap_0.seg4_lit", 32'(kbd.seg4), 32'hC0);
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      b = r < 2 ? 8'hF0 : r == 2 ? 8'hE0 : r < 5 ? letters[$urandom_range(0, 25)] :
          r < 7 ? digits[$urandom_range(0, 9)] : 8'($urandom_range(0, 255));
      r = int'($urandom_range(0, 9));
      send(b, r == 0, r == 1);
      check_all("random");
    end
    send(8'h29, 0, 0, 5);
    do_reset();
    check_all("mid_reset");
    send(8'h29);
    check_all("after_mid_reset");
    chk("after_mid_reset.ascii_lit", 32'(kbd.ascii), 32'h20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
